// File: rtl/decoder_proj_pkg.sv
// ---------------------------------------------------------------------------
// decoder_proj_pkg
// Shared constants and types for the decoder_proj input front end.
//   CODE_W          : width of the pad code fed to decoder_proj
//   GLITCH_W        : width of the saturating glitch counter
//   sampler_state_t : debounce FSM states (IDLE, SETTLE, HOLD)
// ---------------------------------------------------------------------------
package decoder_proj_pkg;

  localparam int CODE_W   = 7;
  localparam int GLITCH_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } sampler_state_t;

endpackage

// File: rtl/decoder_in_sync.sv
// ---------------------------------------------------------------------------
// decoder_in_sync
// Multi-flop synchroniser for a bus of asynchronous pad bits. Every stage
// clears to zero on a synchronous active-high reset.
// Ports:
//   clock : sampling clock
//   reset : synchronous active-high reset
//   d     : raw asynchronous bus (WIDTH bits)
//   q     : synchronised bus, STAGES clocks behind d
// ---------------------------------------------------------------------------
module decoder_in_sync #(
  parameter int WIDTH  = 7,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  // Shift register: stage 0 captures the pad, the last stage is the output.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/decoder_in_sampler.sv
// ---------------------------------------------------------------------------
// decoder_in_sampler
// Synchronises and debounces the raw pad code, then offers each new stable
// code (different from the last delivered one) once over valid/ready.
// Ports:
//   wb_clk_i     : the only clock
//   wb_rst_i     : synchronous active-high reset
//   io_in        : raw asynchronous pad code (CODE_W)
//   code_o       : debounced code, frozen while code_valid_o is high
//   code_valid_o : a new code is being offered
//   code_ready_i : downstream accepts code_o
//   glitch_cnt_o : saturating count of rejected transitions (8 bits)
// Configuration:
//   DECODER_IN_SAMPLER_GLITCH_CNT_EN : when defined the glitch counter is
//   built; otherwise glitch_cnt_o is tied to zero.
// ---------------------------------------------------------------------------
module decoder_in_sampler #(
  parameter int CODE_W        = 7,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [CODE_W-1:0] io_in,
  output logic [CODE_W-1:0] code_o,
  output logic              code_valid_o,
  input  logic              code_ready_i,
  output logic [7:0]        glitch_cnt_o
);

  import decoder_proj_pkg::*;

  localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [CODE_W-1:0] sync;
  logic [CODE_W-1:0] last;
  logic [CODE_W-1:0] cand;
  logic [CNT_W-1:0]  cnt;
  sampler_state_t    state;

  decoder_in_sync #(
    .WIDTH  (CODE_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock (wb_clk_i),
    .reset (wb_rst_i),
    .d     (io_in),
    .q     (sync)
  );

  // Debounce FSM. SETTLE restarts whenever the synchronised code moves; a
  // code that settles back onto the last delivered value is dropped silently
  // so the downstream decoder never sees a repeat.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      last         <= '0;
      cand         <= '0;
      cnt          <= '0;
      code_o       <= '0;
      code_valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sync != last) begin
            cand  <= sync;
            cnt   <= '0;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (sync != cand) begin
            cand <= sync;
            cnt  <= '0;
          end else if (cnt == CNT_LAST) begin
            if (cand == last) begin
              state <= IDLE;
            end else begin
              code_o       <= cand;
              last         <= cand;
              code_valid_o <= 1'b1;
              state        <= HOLD;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (code_ready_i) begin
            code_valid_o <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DECODER_IN_SAMPLER_GLITCH_CNT_EN
  logic                glitch_evt;
  logic [GLITCH_W-1:0] glitch_cnt;

  // A glitch is either a mid-settle change or a settle that bounced back.
  assign glitch_evt = (state == SETTLE) &&
                      ((sync != cand) || ((cnt == CNT_LAST) && (cand == last)));

  // Saturating counter: sticks at all-ones instead of wrapping.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      glitch_cnt <= '0;
    end else if (glitch_evt && (glitch_cnt != {GLITCH_W{1'b1}})) begin
      glitch_cnt <= glitch_cnt + 1'b1;
    end
  end

  assign glitch_cnt_o = glitch_cnt;
`else
  assign glitch_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_decoder_in_sampler.sv
// ---------------------------------------------------------------------------
// tb_decoder_in_sampler
// Directed scenarios plus a randomized run, each clock edge compared against
// a behavioural model of the debounce rules.
// ---------------------------------------------------------------------------
module tb_decoder_in_sampler;

  localparam int CODE_W = 7;
  localparam int STAGES = 2;
  localparam int STABLE = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [CODE_W-1:0] io = '0;
  logic              ready = 1'b0;
  logic [CODE_W-1:0] code_o;
  logic              code_valid_o;
  logic [7:0]        glitch_cnt_o;

  int compared = 0;
  int mismatched = 0;

  decoder_in_sampler #(
    .CODE_W        (CODE_W),
    .SYNC_STAGES   (STAGES),
    .STABLE_CYCLES (STABLE)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .io_in        (io),
    .code_o       (code_o),
    .code_valid_o (code_valid_o),
    .code_ready_i (ready),
    .glitch_cnt_o (glitch_cnt_o)
  );

  always #5 clk = ~clk;

  // Behavioural model: pad history queue plus a phase describing whether we
  // are waiting for a change, watching a candidate settle, or offering it.
  localparam int PH_WAIT = 0, PH_SETTLE = 1, PH_OFFER = 2;
  int                ph = PH_WAIT;
  logic [CODE_W-1:0] m_code = '0, m_last = '0, m_cand = '0;
  int                m_run = 0;
  logic              m_valid = 1'b0;
  int                m_glitch = 0;
  logic [CODE_W-1:0] m_pipe[$];

  function automatic void bumpGlitch();
    if (m_glitch < 255) m_glitch++;
  endfunction

  function automatic void modelEdge(logic r, logic [CODE_W-1:0] pad, logic rdy);
    logic [CODE_W-1:0] s;
    if (r) begin
      ph = PH_WAIT; m_code = '0; m_last = '0; m_cand = '0;
      m_run = 0; m_valid = 1'b0; m_glitch = 0;
      m_pipe.delete();
      for (int i = 0; i < STAGES; i++) m_pipe.push_back('0);
      return;
    end
    s = m_pipe[STAGES-1];
    if (ph == PH_WAIT) begin
      if (s != m_last) begin m_cand = s; m_run = 0; ph = PH_SETTLE; end
    end else if (ph == PH_SETTLE) begin
      if (s != m_cand) begin
        m_cand = s; m_run = 0; bumpGlitch();
      end else if (m_run == STABLE - 1) begin
        if (m_cand == m_last) begin
          bumpGlitch(); ph = PH_WAIT;
        end else begin
          m_code = m_cand; m_last = m_cand; m_valid = 1'b1; ph = PH_OFFER;
        end
      end else begin
        m_run++;
      end
    end else if (rdy) begin
      m_valid = 1'b0; ph = PH_WAIT;
    end
    m_pipe.push_front(pad);
    void'(m_pipe.pop_back());
  endfunction

  function automatic int expGlitch(int g);
`ifdef DECODER_IN_SAMPLER_GLITCH_CNT_EN
    return g;
`else
    return 0;
`endif
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    cmp({tag, "_code"},   32'(code_o),       32'(m_code));
    cmp({tag, "_valid"},  32'(code_valid_o), 32'(m_valid));
    cmp({tag, "_glitch"}, 32'(glitch_cnt_o), 32'(expGlitch(m_glitch)));
  endtask

  task automatic applyStimulus(input logic r, input logic [CODE_W-1:0] pad, input logic rdy);
    rst = r; io = pad; ready = rdy;
  endtask

  // One clock edge: model sees the same inputs the DUT sampled, then compare.
  task automatic tick(input string tag);
    logic r; logic [CODE_W-1:0] pad; logic rdy;
    r = rst; pad = io; rdy = ready;
    @(posedge clk);
    modelEdge(r, pad, rdy);
    #1;
    checkOutput(tag);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, io, ready);
    tick("reset");
    tick("reset");
    rst = 1'b0;
  endtask

  task automatic waitValid(input string tag, input int limit, output int edges);
    edges = 0;
    while (!code_valid_o && edges < limit) begin
      tick(tag);
      edges++;
    end
    cmp({tag, "_timeout"}, 32'(code_valid_o), 32'd1);
  endtask

  initial begin
    int edges, seen, g0;

    // Reset state
    doReset();
    cmp("rst_code", 32'(code_o), 32'h0);
    cmp("rst_valid", 32'(code_valid_o), 32'h0);
    cmp("rst_glitch", 32'(glitch_cnt_o), 32'h0);

    // Basic transfer: valid appears after edge 7 for one cycle
    applyStimulus(1'b0, 7'h78, 1'b1);
    for (int e = 1; e <= 6; e++) tick("basic");
    cmp("basic_pre_valid", 32'(code_valid_o), 32'd0);
    tick("basic");
    cmp("basic_valid_e7", 32'(code_valid_o), 32'd1);
    cmp("basic_code_e7", 32'(code_o), 32'h78);
    seen = 0;
    for (int e = 0; e < 12; e++) begin tick("basic_quiet"); if (code_valid_o) seen++; end
    cmp("basic_single", 32'(seen), 32'd0);

    // Glitch: 0x78 for two cycles then 0x05 held
    doReset();
    applyStimulus(1'b0, 7'h78, 1'b1);
    tick("glitch"); tick("glitch");
    io = 7'h05;
    seen = 0;
    for (int e = 0; e < 20; e++) begin
      tick("glitch");
      if (code_valid_o) begin
        seen++;
        cmp("glitch_code", 32'(code_o), 32'h05);
      end
    end
    cmp("glitch_transfers", 32'(seen), 32'd1);
    cmp("glitch_count", 32'(glitch_cnt_o), 32'(expGlitch(1)));

    // Bounce back onto the last delivered code
    doReset();
    applyStimulus(1'b0, 7'h78, 1'b1);
    waitValid("bounce_setup", 20, edges);
    tick("bounce_setup");
    for (int e = 0; e < 4; e++) tick("bounce_setup");
    g0 = glitch_cnt_o;
    io = 7'h11;
    tick("bounce"); tick("bounce");
    io = 7'h78;
    seen = 0;
    for (int e = 0; e < 20; e++) begin tick("bounce"); if (code_valid_o) seen++; end
    cmp("bounce_no_xfer", 32'(seen), 32'd0);
    cmp("bounce_glitch", 32'(glitch_cnt_o), 32'(expGlitch(g0 + 2)));

    // Backpressure: code held while ready is low and the pad moves
    doReset();
    applyStimulus(1'b0, 7'h78, 1'b0);
    waitValid("bp_first", 20, edges);
    io = 7'h22;
    for (int e = 0; e < 10; e++) begin
      tick("bp_hold");
      cmp("bp_hold_code", 32'(code_o), 32'h78);
      cmp("bp_hold_valid", 32'(code_valid_o), 32'd1);
    end
    ready = 1'b1;
    tick("bp_handshake");
    cmp("bp_dropped", 32'(code_valid_o), 32'd0);
    waitValid("bp_second", 20, edges);
    cmp("bp_second_code", 32'(code_o), 32'h22);
    cmp("bp_spacing", 32'(edges), 32'(STABLE + 1));

    // Reset while holding a code
    doReset();
    applyStimulus(1'b0, 7'h78, 1'b0);
    waitValid("rh_first", 20, edges);
    rst = 1'b1;
    tick("rh_reset");
    cmp("rh_valid", 32'(code_valid_o), 32'd0);
    cmp("rh_code", 32'(code_o), 32'h0);
    rst = 1'b0;
    waitValid("rh_again", 20, edges);
    cmp("rh_latency", 32'(edges), 32'(STAGES + STABLE + 1));
    cmp("rh_again_code", 32'(code_o), 32'h78);

    // Saturation: pad toggling every cycle keeps rejecting candidates
    doReset();
    applyStimulus(1'b0, 7'h01, 1'b1);
    for (int e = 0; e < 310; e++) begin
      io = (e % 2 == 0) ? 7'h01 : 7'h02;
      tick("sat");
    end
`ifdef DECODER_IN_SAMPLER_GLITCH_CNT_EN
    cmp("sat_glitch", 32'(glitch_cnt_o), 32'd255);
`else
    cmp("sat_glitch", 32'(glitch_cnt_o), 32'd0);
`endif

    // Randomized run against the model
    doReset();
    for (int e = 0; e < 800; e++) begin
      if ($urandom_range(0, 5) == 0) io = CODE_W'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 249) == 0);
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
